pipe_stage_reg: RTL and testbench

Generic parametrised pipeline stage register that replaces the hand-written per-stage registers such as IF/ID and EX/MEM. It carries one packed DATA_W-bit bundle of control and data fields, plus a valid bit and a valid/ready handshake for stalls. It supports a flush that converts the stage into a bubble. An optional 2-entry skid mode registers in_ready to break the combinational stall path between pipeline stages.

---
 rtl/pipe_stage_reg.sv | 97 +++++++++
 tb/tb_pipe_stage_reg.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake and flush.
// SKID=1 adds a second entry so that in_ready comes straight from a flop.
module pipe_stage_reg #(
  parameter int                DATA_W    = 32,
  parameter int                SKID      = 0,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [1:0]        occupancy
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              rdy_q, rdy_d;
  logic              in_xfer, out_xfer;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = data_q;
  assign occupancy = state_q;

  // rdy_q is the registered ready in skid mode; in single mode it only
  // keeps in_ready low until the first edge after reset release.
  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = rdy_q;
    end else begin : g_single
      assign in_ready = rdy_q & (out_ready | ~out_valid);
    end
  endgenerate

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            data_d  = in_data;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            data_d = in_data;
          end else if (in_xfer && (SKID != 0)) begin
            skid_d  = in_data;
            state_d = ST_TWO;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_xfer) begin
            data_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    rdy_d = (SKID != 0) ? (state_d != ST_TWO) : 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      data_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      skid_q  <= skid_d;
      rdy_q   <= rdy_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and randomised checks of pipe_stage_reg in single (dut0) and
// skid (dut1) configurations, both driven from the same upstream/downstream.
module tb_pipe_stage_reg;

  localparam logic [31:0] RV = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        out_ready = 1'b0;
  logic        flush = 1'b0;

  logic        r0_in_ready, r0_out_valid;
  logic [31:0] r0_out_data;
  logic [1:0]  r0_occ;
  logic        r1_in_ready, r1_out_valid;
  logic [31:0] r1_out_data;
  logic [1:0]  r1_occ;

  int total = 0;
  int bad   = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  bit          rdy1_m;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(32), .SKID(0), .RESET_VAL(RV)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r0_in_ready),
    .in_data(in_data), .out_valid(r0_out_valid), .out_ready(out_ready),
    .out_data(r0_out_data), .flush(flush), .occupancy(r0_occ)
  );

  pipe_stage_reg #(.DATA_W(32), .SKID(1), .RESET_VAL(RV)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r1_in_ready),
    .in_data(in_data), .out_valid(r1_out_valid), .out_ready(out_ready),
    .out_data(r1_out_data), .flush(flush), .occupancy(r1_occ)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cyc();
    total++; if (r0_out_valid !== 1'b0) begin bad++; $display("FAIL rst0_valid got=%b exp=0", r0_out_valid); end
    total++; if (r0_out_data !== RV) begin bad++; $display("FAIL rst0_data got=%h exp=%h", r0_out_data, RV); end
    total++; if (r1_occ !== 2'd0) begin bad++; $display("FAIL rst1_occ got=%0d exp=0", r1_occ); end
    total++; if (r1_out_data !== RV) begin bad++; $display("FAIL rst1_data got=%h exp=%h", r1_out_data, RV); end
    total++; if (r0_in_ready !== 1'b0) begin bad++; $display("FAIL rst0_ready got=%b exp=0", r0_in_ready); end
    total++; if (r1_in_ready !== 1'b0) begin bad++; $display("FAIL rst1_ready got=%b exp=0", r1_in_ready); end
    rst = 1'b1;
    #1;
    total++; if (r0_in_ready !== 1'b0) begin bad++; $display("FAIL rel0_ready_pre got=%b exp=0", r0_in_ready); end
    cyc();
    total++; if (r0_in_ready !== 1'b1) begin bad++; $display("FAIL rel0_ready got=%b exp=1", r0_in_ready); end
    total++; if (r1_in_ready !== 1'b1) begin bad++; $display("FAIL rel1_ready got=%b exp=1", r1_in_ready); end
    $display("test_reset done");
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = 32'(i);
      cyc();
      total++; if (r0_out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, r0_out_valid); end
      total++; if (r0_out_data !== 32'(i)) begin bad++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, r0_out_data, 32'(i)); end
      total++; if (r0_occ !== 2'd1) begin bad++; $display("FAIL stream_occ[%0d] got=%0d exp=1", i, r0_occ); end
      total++; if (r1_out_data !== 32'(i)) begin bad++; $display("FAIL stream1_data[%0d] got=%h exp=%h", i, r1_out_data, 32'(i)); end
      $display("stream beat %0d out=%h", i, r0_out_data);
    end
    in_valid = 1'b0;
    cyc();
    total++; if (r0_out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain got=%b exp=0", r0_out_valid); end
  endtask

  task automatic test_stall();
    in_valid = 1'b1;
    in_data  = 32'h0000_00A5;
    cyc();
    out_ready = 1'b0;
    in_data   = 32'h0000_005A;
    #1;
    total++; if (r0_in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready got=%b exp=0", r0_in_ready); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++; if (r0_out_data !== 32'hA5) begin bad++; $display("FAIL stall_hold[%0d] got=%h exp=000000a5", i, r0_out_data); end
      total++; if (r0_out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d] got=%b exp=1", i, r0_out_valid); end
      total++; if (r0_in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready[%0d] got=%b exp=0", i, r0_in_ready); end
    end
    out_ready = 1'b1;
    cyc();
    total++; if (r0_out_data !== 32'h5A) begin bad++; $display("FAIL stall_resume got=%h exp=0000005a", r0_out_data); end
    total++; if (r0_out_valid !== 1'b1) begin bad++; $display("FAIL stall_resume_valid got=%b exp=1", r0_out_valid); end
    in_valid = 1'b0;
    cyc();
    total++; if (r0_out_valid !== 1'b0) begin bad++; $display("FAIL stall_drain got=%b exp=0", r0_out_valid); end
    $display("test_stall done");
  endtask

  task automatic test_skid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h11;
    cyc();
    total++; if (r1_occ !== 2'd1) begin bad++; $display("FAIL skid_occ1 got=%0d exp=1", r1_occ); end
    total++; if (r1_in_ready !== 1'b1) begin bad++; $display("FAIL skid_ready1 got=%b exp=1", r1_in_ready); end
    in_data = 32'h22;
    cyc();
    total++; if (r1_occ !== 2'd2) begin bad++; $display("FAIL skid_occ2 got=%0d exp=2", r1_occ); end
    total++; if (r1_in_ready !== 1'b0) begin bad++; $display("FAIL skid_ready2 got=%b exp=0", r1_in_ready); end
    total++; if (r1_out_data !== 32'h11) begin bad++; $display("FAIL skid_head got=%h exp=00000011", r1_out_data); end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc();
    total++; if (r1_out_data !== 32'h22) begin bad++; $display("FAIL skid_second got=%h exp=00000022", r1_out_data); end
    total++; if (r1_occ !== 2'd1) begin bad++; $display("FAIL skid_occ_drain got=%0d exp=1", r1_occ); end
    total++; if (r1_in_ready !== 1'b1) begin bad++; $display("FAIL skid_ready_back got=%b exp=1", r1_in_ready); end
    cyc();
    total++; if (r1_out_valid !== 1'b0) begin bad++; $display("FAIL skid_empty got=%b exp=0", r1_out_valid); end
    $display("test_skid done");
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hAA;
    cyc();
    in_data = 32'hBB;
    cyc();
    total++; if (r1_occ !== 2'd2) begin bad++; $display("FAIL flush_pre_occ got=%0d exp=2", r1_occ); end
    flush   = 1'b1;
    in_data = 32'h33;
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    total++; if (r1_out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", r1_out_valid); end
    total++; if (r1_occ !== 2'd0) begin bad++; $display("FAIL flush_occ got=%0d exp=0", r1_occ); end
    total++; if (r1_in_ready !== 1'b1) begin bad++; $display("FAIL flush_ready1 got=%b exp=1", r1_in_ready); end
    total++; if (r0_in_ready !== 1'b1) begin bad++; $display("FAIL flush_ready0 got=%b exp=1", r0_in_ready); end
    total++; if (r1_out_data !== 32'hAA) begin bad++; $display("FAIL flush_payload got=%h exp=000000aa", r1_out_data); end
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      total++; if (r1_out_valid !== 1'b0) begin bad++; $display("FAIL flush_no33[%0d] got=%b exp=0", i, r1_out_valid); end
      total++; if (r0_out_valid !== 1'b0) begin bad++; $display("FAIL flush0_empty[%0d] got=%b exp=0", i, r0_out_valid); end
    end
    $display("test_flush done");
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h1;
    cyc();
    in_data = 32'h2;
    cyc();
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    total++; if (r0_out_valid !== 1'b0) begin bad++; $display("FAIL mrst0_valid got=%b exp=0", r0_out_valid); end
    total++; if (r0_out_data !== RV) begin bad++; $display("FAIL mrst0_data got=%h exp=%h", r0_out_data, RV); end
    total++; if (r1_occ !== 2'd0) begin bad++; $display("FAIL mrst1_occ got=%0d exp=0", r1_occ); end
    total++; if (r1_out_data !== RV) begin bad++; $display("FAIL mrst1_data got=%h exp=%h", r1_out_data, RV); end
    total++; if (r1_in_ready !== 1'b0) begin bad++; $display("FAIL mrst1_ready got=%b exp=0", r1_in_ready); end
    cyc();
    rst = 1'b1;
    cyc();
    total++; if (r0_in_ready !== 1'b1) begin bad++; $display("FAIL mrel0_ready got=%b exp=1", r0_in_ready); end
    total++; if (r1_in_ready !== 1'b1) begin bad++; $display("FAIL mrel1_ready got=%b exp=1", r1_in_ready); end
    $display("test_mid_reset done");
  endtask

  task automatic test_random();
    bit rdy0, inx0, inx1, outx0, outx1;
    q0.delete();
    q1.delete();
    rdy1_m = 1'b1;
    for (int i = 0; i < 10000 && bad <= 20; i++) begin
      total++; if (r0_out_valid !== (q0.size() > 0)) begin bad++; $display("FAIL rnd0_valid[%0d] got=%b exp=%b", i, r0_out_valid, q0.size() > 0); end
      total++; if (r1_out_valid !== (q1.size() > 0)) begin bad++; $display("FAIL rnd1_valid[%0d] got=%b exp=%b", i, r1_out_valid, q1.size() > 0); end
      total++; if (r0_occ !== 2'(q0.size())) begin bad++; $display("FAIL rnd0_occ[%0d] got=%0d exp=%0d", i, r0_occ, q0.size()); end
      total++; if (r1_occ !== 2'(q1.size())) begin bad++; $display("FAIL rnd1_occ[%0d] got=%0d exp=%0d", i, r1_occ, q1.size()); end
      if (q0.size() > 0) begin
        total++; if (r0_out_data !== q0[0]) begin bad++; $display("FAIL rnd0_data[%0d] got=%h exp=%h", i, r0_out_data, q0[0]); end
      end
      if (q1.size() > 0) begin
        total++; if (r1_out_data !== q1[0]) begin bad++; $display("FAIL rnd1_data[%0d] got=%h exp=%h", i, r1_out_data, q1[0]); end
      end
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 99) < 3);
      in_data   = $urandom;
      #1;
      rdy0 = (q0.size() == 0) || out_ready;
      total++; if (r0_in_ready !== rdy0) begin bad++; $display("FAIL rnd0_ready[%0d] got=%b exp=%b", i, r0_in_ready, rdy0); end
      total++; if (r1_in_ready !== rdy1_m) begin bad++; $display("FAIL rnd1_ready[%0d] got=%b exp=%b", i, r1_in_ready, rdy1_m); end
      inx0  = in_valid && rdy0;
      inx1  = in_valid && rdy1_m;
      outx0 = (q0.size() > 0) && out_ready;
      outx1 = (q1.size() > 0) && out_ready;
      if (flush) begin
        q0.delete();
        q1.delete();
      end else begin
        if (outx0) void'(q0.pop_front());
        if (inx0) q0.push_back(in_data);
        if (outx1) void'(q1.pop_front());
        if (inx1) q1.push_back(in_data);
      end
      rdy1_m = (q1.size() < 2);
      cyc();
    end
    flush = 1'b0;
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_skid();
    test_flush();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
